hamming_argmin: RTL

Streaming nearest-class search that consumes the per-entry similarity results produced by the bit counter (Hamming distance plus associative-memory address, one entry per cycle) and returns the closest class. It sits downstream of the bit counter in the associative-memory search path. Each search tracks the minimum and second-minimum distance over a programmed number of entries, then presents the winning address, its distance and a confidence margin with a one-cycle done pulse.

---
 rtl/hamming_argmin.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hamming_argmin.sv
// hamming_argmin: streaming nearest-class search over bit-counter results.
// Consumes one (distance, address) pair per cycle, tracks the smallest and
// second-smallest distance over a programmed number of entries, and reports
// the winning address, its distance and the margin to the runner-up with a
// one-cycle done pulse.
module hamming_argmin #(
  parameter  int N             = 2048,
  parameter  int AM_ADDR_WIDTH = 13,
  localparam int CNT_W         = $clog2(N + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [AM_ADDR_WIDTH:0]   num_entries_i,
  input  logic                     in_valid,
  input  logic [CNT_W-1:0]         bit_count_in,
  input  logic [AM_ADDR_WIDTH-1:0] in_addr,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AM_ADDR_WIDTH-1:0] best_addr_o,
  output logic [CNT_W-1:0]         best_count_o,
  output logic [CNT_W-1:0]         second_count_o,
  output logic [CNT_W-1:0]         margin_o
);

  // Constant patterns used for reload and reset.
  localparam logic [CNT_W-1:0]         CNT_ONES  = {CNT_W{1'b1}};
  localparam logic [AM_ADDR_WIDTH-1:0] ADDR_ZERO = {AM_ADDR_WIDTH{1'b0}};
  localparam logic [AM_ADDR_WIDTH:0]   ENT_ZERO  = {(AM_ADDR_WIDTH + 1){1'b0}};
  localparam logic [AM_ADDR_WIDTH:0]   ENT_ONE   = {{AM_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                     state_r;
  logic [AM_ADDR_WIDTH:0]     num_r;
  logic [AM_ADDR_WIDTH:0]     cnt_r;
  logic [CNT_W-1:0]           best_r;
  logic [CNT_W-1:0]           second_r;
  logic [AM_ADDR_WIDTH-1:0]   addr_r;
  logic                       busy_r;
  logic                       done_r;

  logic                       lt_best_s;
  logic                       lt_second_s;
  logic [AM_ADDR_WIDTH:0]     cnt_inc_s;
  logic                       last_s;

  // Comparators and entry-count bookkeeping for the incoming entry.
  always_comb begin
    lt_best_s   = 1'b0;
    lt_second_s = 1'b0;
    cnt_inc_s   = cnt_r + ENT_ONE;
    last_s      = 1'b0;
    if (in_valid) begin
      lt_best_s   = (bit_count_in < best_r);
      lt_second_s = (bit_count_in < second_r);
      last_s      = (cnt_inc_s == num_r);
    end else begin
      lt_best_s   = 1'b0;
      lt_second_s = 1'b0;
      last_s      = 1'b0;
    end
  end

  // Search sequencer: IDLE accepts a start, SEARCH folds in each valid
  // entry (strict less-than keeps the earliest address on ties), DONE pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      num_r    <= ENT_ZERO;
      cnt_r    <= ENT_ZERO;
      best_r   <= CNT_ONES;
      second_r <= CNT_ONES;
      addr_r   <= ADDR_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (start_i) begin
            num_r    <= num_entries_i;
            cnt_r    <= ENT_ZERO;
            best_r   <= CNT_ONES;
            second_r <= CNT_ONES;
            addr_r   <= ADDR_ZERO;
            if (num_entries_i != ENT_ZERO) begin
              state_r <= ST_SEARCH;
              busy_r  <= 1'b1;
            end else begin
              // Empty search completes immediately with sentinel results.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SEARCH: begin
          done_r <= 1'b0;
          if (in_valid) begin
            cnt_r <= cnt_inc_s;
            if (lt_best_s) begin
              second_r <= best_r;
              best_r   <= bit_count_in;
              addr_r   <= in_addr;
            end else if (lt_second_s) begin
              second_r <= bit_count_in;
            end else begin
              second_r <= second_r;
            end
            if (last_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_SEARCH;
              busy_r  <= 1'b1;
            end
          end else begin
            // Bubble: hold everything, no timeout.
            state_r <= ST_SEARCH;
            busy_r  <= 1'b1;
          end
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          // Illegal encoding: fall back to a safe idle without a done pulse.
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign best_addr_o    = addr_r;
  assign best_count_o   = best_r;
  assign second_count_o = second_r;
  // second_r >= best_r always holds, so the unsigned difference never wraps.
  assign margin_o       = second_r - best_r;

endmodule
